// File: rtl/io_pkg.sv
// Shared definitions for the memory-mapped I/O ports: bus addresses,
// status-word layout and the strobe/acknowledge handshake states.
package io_pkg;

    localparam logic [7:0] IO_DATA_ADDR = 8'hFF;
    localparam logic [7:0] IO_STAT_ADDR = 8'hFE;

    localparam int STAT_FULL = 0;
    localparam int STAT_OVR  = 1;

    typedef enum logic {
        IDLE,
        WAIT_LOW
    } hs_state_e;

    // Status word as seen by the processor: flags at their fixed bit positions.
    function automatic logic [7:0] status_word(input logic ovr, input logic full);
        logic [7:0] w;
        w            = 8'h00;
        w[STAT_FULL] = full;
        w[STAT_OVR]  = ovr;
        return w;
    endfunction

endpackage

// File: rtl/parallel_in_port_if.sv
// Processor read bus plus external-device handshake of the parallel input port.
// master = processor/device side, slave = the port itself.
interface parallel_in_port_if;

    logic       EN;
    logic [7:0] Address;
    logic [7:0] DataOut;
    logic [7:0] ExtData;
    logic       ExtStb;
    logic       ExtAck;
    logic       Ready;

    modport master (
        output EN, Address, ExtData, ExtStb,
        input  DataOut, ExtAck, Ready
    );

    modport slave (
        input  EN, Address, ExtData, ExtStb,
        output DataOut, ExtAck, Ready
    );

endinterface

// File: rtl/sync_ff.sv
// N-stage single-bit synchronizer with async active-low clear.
// Reusable by any input port that samples an asynchronous strobe.
module sync_ff #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [N-1:0] sync_q;
    logic [N-1:0] sync_d;

    // Shift the raw input in at the bottom of the chain.
    always_comb begin
        sync_d = {sync_q[N-2:0], d};
    end

    // Synchronizer chain, cleared on reset so no stale strobe survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= sync_d;
    end

    assign q = sync_q[N-1];

endmodule

// File: rtl/parallel_in_port.sv
// Memory-mapped 8-bit parallel input port. Captures a byte from an external
// device via a four-phase strobe/acknowledge handshake and lets the processor
// read the byte or a status word over the Address/EN bus.
module parallel_in_port
    import io_pkg::*;
#(
    parameter logic [7:0] DATA_ADDR   = IO_DATA_ADDR,
    parameter logic [7:0] STAT_ADDR   = IO_STAT_ADDR,
    parameter int         SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    parallel_in_port_if.slave bus
);

    logic       ss;
    logic       data_rd;
    logic       stat_rd;
    logic       hs_evt;
    logic       capture;

    hs_state_e  state_q, state_d;
    logic       ack_q,   ack_d;
    logic       full_q,  full_d;
    logic       ovr_q,   ovr_d;
    logic [7:0] data_q,  data_d;
    logic [7:0] dout_q,  dout_d;

    // The strobe is asynchronous; only its synchronized copy reaches the FSM.
    sync_ff #(.N(SYNC_STAGES)) u_stb_sync (
        .clk   (clk),
        .rst_n (rst),
        .d     (bus.ExtStb),
        .q     (ss)
    );

    assign data_rd = bus.EN && (bus.Address == DATA_ADDR);
    assign stat_rd = bus.EN && (bus.Address == STAT_ADDR);
    assign hs_evt  = (state_q == IDLE) && ss;
    // A data read on the same edge frees the slot, so the new byte is not an overrun.
    assign capture = hs_evt && (!full_q || data_rd);

    // Next-state: read mux first, then handshake events override the flags they touch.
    always_comb begin
        state_d = state_q;
        ack_d   = ack_q;
        full_d  = full_q;
        ovr_d   = ovr_q;
        data_d  = data_q;
        dout_d  = dout_q;

        if (data_rd) begin
            dout_d = data_q;
            full_d = 1'b0;
        end else if (stat_rd) begin
            dout_d = status_word(ovr_q, full_q);
            ovr_d  = 1'b0;
        end

        if (hs_evt) begin
            ack_d   = 1'b1;
            state_d = WAIT_LOW;
            if (capture) begin
                data_d = bus.ExtData;
                full_d = 1'b1;
            end else begin
                ovr_d  = 1'b1;
            end
        end else if ((state_q == WAIT_LOW) && !ss) begin
            ack_d   = 1'b0;
            state_d = IDLE;
        end
    end

    // All port state; reset abandons any handshake in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            full_q  <= 1'b0;
            ovr_q   <= 1'b0;
            data_q  <= 8'h00;
            dout_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            full_q  <= full_d;
            ovr_q   <= ovr_d;
            data_q  <= data_d;
            dout_q  <= dout_d;
        end
    end

    assign bus.DataOut = dout_q;
    assign bus.ExtAck  = ack_q;
    assign bus.Ready   = full_q;

endmodule

// File: tb/tb_parallel_in_port.sv
// Scoreboard bench for parallel_in_port: a behavioural model predicts the
// outputs after every clock edge, a monitor compares them against the DUT.
module tb_parallel_in_port;

    localparam int SYNC = 2;

    typedef struct {
        logic [7:0] dout;
        logic       rdy;
        logic       ack;
    } exp_t;

    logic clk;
    logic rst;
    parallel_in_port_if bus();

    parallel_in_port #(.SYNC_STAGES(SYNC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t exp_q[$];
    bit   dev_done;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: strobe seen SYNC edges late, one capture per high pulse,
    // a full port turns a new byte into an overrun unless it is read that same edge.
    initial begin : model
        bit         m_full, m_ovr, m_ack, ss, drd, srd, o_full, o_ovr;
        logic [7:0] m_data, m_dout, o_data;
        bit         hist[$];
        exp_t       e;
        m_full = 0; m_ovr = 0; m_ack = 0; m_data = 0; m_dout = 0;
        forever begin
            @(posedge clk);
            if (!rst) begin
                m_full = 0; m_ovr = 0; m_ack = 0; m_data = 0; m_dout = 0;
                hist = {};
                for (int i = 0; i < SYNC; i++) hist.push_front(1'b0);
            end else begin
                ss     = hist[SYNC-1];
                drd    = bus.EN && (bus.Address == 8'hFF);
                srd    = bus.EN && (bus.Address == 8'hFE);
                o_full = m_full; o_ovr = m_ovr; o_data = m_data;
                if (drd) begin
                    m_dout = o_data; m_full = 0;
                end else if (srd) begin
                    m_dout = {6'b0, o_ovr, o_full}; m_ovr = 0;
                end
                if (!m_ack && ss) begin
                    m_ack = 1;
                    if (!o_full || drd) begin m_data = bus.ExtData; m_full = 1; end
                    else m_ovr = 1;
                end else if (m_ack && !ss) begin
                    m_ack = 0;
                end
                hist.push_front(bus.ExtStb);
                void'(hist.pop_back());
            end
            e.dout = m_dout; e.rdy = m_full; e.ack = m_ack;
            exp_q.push_back(e);
        end
    end

    // Monitor: compares each predicted output set a little after its edge.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_chk += 3;
                if (bus.DataOut !== e.dout) begin
                    n_fail++;
                    $display("FAIL dataout t=%0t got=%h exp=%h", $time, bus.DataOut, e.dout);
                end
                if (bus.Ready !== e.rdy) begin
                    n_fail++;
                    $display("FAIL ready t=%0t got=%b exp=%b", $time, bus.Ready, e.rdy);
                end
                if (bus.ExtAck !== e.ack) begin
                    n_fail++;
                    $display("FAIL extack t=%0t got=%b exp=%b", $time, bus.ExtAck, e.ack);
                end
            end
        end
    end

    // Device side: wait (bounded) for ExtAck to reach v.
    task automatic wait_ack(input bit v);
        int n = 0;
        while (bus.ExtAck !== v && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_chk++;
        if (bus.ExtAck !== v) begin
            n_fail++;
            $display("FAIL ack_timeout t=%0t got=%b exp=%b", $time, bus.ExtAck, v);
        end
    endtask

    task automatic handshake(input logic [7:0] d);
        @(negedge clk);
        bus.ExtData = d;
        bus.ExtStb  = 1'b1;
        wait_ack(1'b1);
        @(negedge clk);
        bus.ExtStb = 1'b0;
        wait_ack(1'b0);
    endtask

    task automatic rd(input logic [7:0] a);
        @(negedge clk);
        bus.EN      = 1'b1;
        bus.Address = a;
        @(negedge clk);
        bus.EN      = 1'b0;
    endtask

    initial begin : stim
        rst = 1'b0;
        bus.EN = 1'b0; bus.Address = 8'h00; bus.ExtData = 8'h00; bus.ExtStb = 1'b0;
        dev_done = 0;
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // basic transfer, status read, unmapped read
        handshake(8'hA5);
        rd(8'hFF);
        handshake(8'h3C);
        rd(8'hFE);
        rd(8'h10);
        rd(8'hFF);

        // overrun: second byte arrives while the first is unread
        handshake(8'h11);
        handshake(8'h22);
        rd(8'hFE);
        rd(8'hFE);
        rd(8'hFF);

        // data read lands on the capture edge of the next byte
        handshake(8'h33);
        @(negedge clk);
        bus.ExtData = 8'h44;
        bus.ExtStb  = 1'b1;
        repeat (2) @(negedge clk);
        bus.EN = 1'b1; bus.Address = 8'hFF;
        @(negedge clk);
        bus.EN = 1'b0;
        wait_ack(1'b1);
        bus.ExtStb = 1'b0;
        wait_ack(1'b0);
        rd(8'hFE);
        rd(8'hFF);

        // reset in the middle of a handshake; held strobe is a fresh capture
        @(negedge clk);
        bus.ExtData = 8'h66;
        bus.ExtStb  = 1'b1;
        wait_ack(1'b1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        wait_ack(1'b1);
        @(negedge clk);
        bus.ExtStb = 1'b0;
        wait_ack(1'b0);
        rd(8'hFE);
        rd(8'hFF);

        // long strobe: one capture only
        @(negedge clk);
        bus.ExtData = 8'h5A;
        bus.ExtStb  = 1'b1;
        repeat (50) @(negedge clk);
        bus.ExtStb = 1'b0;
        wait_ack(1'b0);
        rd(8'hFE);
        rd(8'hFF);

        // random device traffic against random processor reads
        fork
            begin
                for (int k = 0; k < 40; k++) begin
                    repeat ($urandom_range(0, 6)) @(negedge clk);
                    @(negedge clk);
                    bus.ExtData = 8'($urandom);
                    bus.ExtStb  = 1'b1;
                    wait_ack(1'b1);
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    @(negedge clk);
                    bus.ExtStb = 1'b0;
                    wait_ack(1'b0);
                end
                dev_done = 1;
            end
            begin
                while (!dev_done) begin
                    @(negedge clk);
                    bus.EN = 1'($urandom_range(0, 1));
                    case ($urandom_range(0, 3))
                        0:       bus.Address = 8'hFF;
                        1:       bus.Address = 8'hFE;
                        default: bus.Address = 8'($urandom);
                    endcase
                end
                @(negedge clk);
                bus.EN = 1'b0;
            end
        join

        rd(8'hFE);
        rd(8'hFF);
        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
